// File: rtl/truth_table_walker.sv
// Walks every input row of a small gate, checks its output against EXPECTED, reports pass/mask/first failing row.
// Optional build macro TRUTH_TABLE_WALKER_STOP_ON_FAIL_EN: end the walk at the first mismatching row.
module truth_table_walker #(
  parameter int                      N_INPUTS      = 2,
  parameter int                      SETTLE_CYCLES = 2,
  parameter logic [2**N_INPUTS-1:0]  EXPECTED      = 4'b0111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_INPUTS-1:0]      stim,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2**N_INPUTS-1:0]   mismatch_mask,
  output logic [N_INPUTS-1:0]      fail_index
);

  localparam int ROWS = 2**N_INPUTS;
  localparam int RW   = N_INPUTS + 1;
  localparam int CW   = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  if (N_INPUTS < 1 || N_INPUTS > 4) begin : g_bad_n_inputs
    $error("truth_table_walker: N_INPUTS must be in 1..4");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("truth_table_walker: SETTLE_CYCLES must be at least 1");
  end

  // state  | meaning
  // IDLE   | waiting for start, stim held at 0, results held
  // SETTLE | current row driven, waiting SETTLE_CYCLES cycles
  // SAMPLE | compare dut_out with EXPECTED[row], advance or finish
  // DONE   | one-cycle done pulse, pass valid
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_INPUTS-1:0]  stim_q, stim_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ROWS-1:0]      mask_q, mask_d;
  logic [N_INPUTS-1:0]  fail_q, fail_d;
  logic [N_INPUTS-1:0]  row_idx;
  logic                 miss;
  logic                 finish;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    fail_d  = fail_q;
    row_idx = row_q[N_INPUTS-1:0];
    miss    = (dut_out != EXPECTED[row_idx]);
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        stim_d = '0;
        if (start) begin
          state_d = SETTLE;
          row_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = '0;
          fail_d  = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        mask_d[row_idx] = miss;
        // mask_q is still empty only until the first mismatch of this walk
        if (miss && (mask_q == '0)) fail_d = row_idx;
`ifdef TRUTH_TABLE_WALKER_STOP_ON_FAIL_EN
        finish = (row_q == ROW_LAST) || miss;
`else
        finish = (row_q == ROW_LAST);
`endif
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mask_d == '0);
        end else begin
          state_d = SETTLE;
          row_d   = row_q + RW'(1);
          stim_d  = row_d[N_INPUTS-1:0];
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        stim_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      fail_q  <= fail_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch_mask = mask_q;
  assign fail_index    = fail_q;

endmodule

// File: tb/tb_truth_table_walker.sv
// Directed bench: NAND (2-input) and inverter (1-input) walkers with hand-computed results.
module tb_truth_table_walker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] stim;
  logic       dut_out;
  logic       busy, done, pass;
  logic [3:0] mask;
  logic [1:0] fidx;
  int         mode = 0;

  logic       start_i = 1'b0;
  logic [0:0] stim_i;
  logic       dut_out_i;
  logic       busy_i, done_i, pass_i;
  logic [1:0] mask_i;
  logic [0:0] fidx_i;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // mode 0: NAND, 1: stuck at 1, 2: stuck at 0
  assign dut_out   = (mode == 0) ? ~(stim[0] & stim[1]) : (mode == 1);
  assign dut_out_i = ~stim_i[0];

  truth_table_walker #(.N_INPUTS(2), .SETTLE_CYCLES(2), .EXPECTED(4'b0111)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .mismatch_mask(mask), .fail_index(fidx));

  truth_table_walker #(.N_INPUTS(1), .SETTLE_CYCLES(2), .EXPECTED(2'b01)) u_inv (
    .clk(clk), .rst_n(rst_n), .start(start_i), .stim(stim_i), .dut_out(dut_out_i),
    .busy(busy_i), .done(done_i), .pass(pass_i), .mismatch_mask(mask_i), .fail_index(fidx_i));

  task automatic run_main(input int x1, input int x2, input int x3,
                          output int done_edge, output int busy_cnt, output int done_cnt,
                          output int stim_bad, output logic pass_at0,
                          output logic [3:0] mask_at0, output logic [1:0] fidx_at0);
    int e;
    done_edge = -1; busy_cnt = 0; done_cnt = 0; stim_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0; e = 0;
    pass_at0 = pass; mask_at0 = mask; fidx_at0 = fidx;
    while (e < 40 && !(done_edge >= 0 && e >= done_edge + 2)) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end else if (done_edge < 0 && e < 12 && stim !== 2'(e / 3)) stim_bad++;
      start = (e + 1 == x1) || (e + 1 == x2) || (e + 1 == x3);
      @(posedge clk); @(negedge clk); e++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (stim !== 2'd0) $display("FAIL reset_stim got %0d exp 0", stim); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %b exp 0", pass); else passed++;
    checks++; if (mask !== 4'd0 || fidx !== 2'd0) $display("FAIL reset_mask_fidx got %b/%0d exp 0000/0", mask, fidx); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nand();
    int de, bc, dc, sb; logic p0; logic [3:0] m0; logic [1:0] f0;
    mode = 0;
    run_main(0, 0, 0, de, bc, dc, sb, p0, m0, f0);
    checks++; if (de !== 12) $display("FAIL nand_done_edge got %0d exp 12", de); else passed++;
    checks++; if (bc !== 12) $display("FAIL nand_busy_cycles got %0d exp 12", bc); else passed++;
    checks++; if (dc !== 1) $display("FAIL nand_done_count got %0d exp 1", dc); else passed++;
    checks++; if (sb !== 0) $display("FAIL nand_stim_sequence got %0d bad cycles exp 0", sb); else passed++;
    checks++; if (pass !== 1'b1 || mask !== 4'b0000 || fidx !== 2'd0)
      $display("FAIL nand_result got pass=%b mask=%b fidx=%0d exp 1/0000/0", pass, mask, fidx); else passed++;
    checks++; if (stim !== 2'd0) $display("FAIL nand_stim_idle got %0d exp 0", stim); else passed++;
  endtask

  task automatic test_stuck1();
    int de, bc, dc, sb; logic p0; logic [3:0] m0; logic [1:0] f0;
    mode = 1;
    run_main(0, 0, 0, de, bc, dc, sb, p0, m0, f0);
    checks++; if (de !== 12) $display("FAIL stuck1_done_edge got %0d exp 12", de); else passed++;
    checks++; if (pass !== 1'b0 || mask !== 4'b1000 || fidx !== 2'd3)
      $display("FAIL stuck1_result got pass=%b mask=%b fidx=%0d exp 0/1000/3", pass, mask, fidx); else passed++;
  endtask

  task automatic test_stuck0();
    int de, bc, dc, sb; logic p0; logic [3:0] m0; logic [1:0] f0;
    mode = 2;
    run_main(0, 0, 0, de, bc, dc, sb, p0, m0, f0);
    checks++; if (m0 !== 4'b0000 || f0 !== 2'd0)
      $display("FAIL stuck0_clear_at_start got mask=%b fidx=%0d exp 0000/0", m0, f0); else passed++;
`ifdef TRUTH_TABLE_WALKER_STOP_ON_FAIL_EN
    checks++; if (de !== 3) $display("FAIL stuck0_done_edge got %0d exp 3", de); else passed++;
    checks++; if (pass !== 1'b0 || mask !== 4'b0001 || fidx !== 2'd0)
      $display("FAIL stuck0_result got pass=%b mask=%b fidx=%0d exp 0/0001/0", pass, mask, fidx); else passed++;
`else
    checks++; if (de !== 12) $display("FAIL stuck0_done_edge got %0d exp 12", de); else passed++;
    checks++; if (pass !== 1'b0 || mask !== 4'b0111 || fidx !== 2'd0)
      $display("FAIL stuck0_result got pass=%b mask=%b fidx=%0d exp 0/0111/0", pass, mask, fidx); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    int de, bc, dc, sb; logic p0; logic [3:0] m0; logic [1:0] f0;
    mode = 0;
    run_main(3, 12, 13, de, bc, dc, sb, p0, m0, f0);
    checks++; if (de !== 12 || dc !== 1) $display("FAIL b2b_done got edge=%0d count=%0d exp 12/1", de, dc); else passed++;
    checks++; if (sb !== 0) $display("FAIL b2b_stim_sequence got %0d bad cycles exp 0", sb); else passed++;
    checks++; if (busy !== 1'b0 || pass !== 1'b1) $display("FAIL b2b_idle got busy=%b pass=%b exp 0/1", busy, pass); else passed++;
    mode = 1;
    run_main(0, 0, 0, de, bc, dc, sb, p0, m0, f0);
    checks++; if (p0 !== 1'b0) $display("FAIL restart_pass_cleared got %b exp 0", p0); else passed++;
    checks++; if (mask !== 4'b1000 || fidx !== 2'd3) $display("FAIL restart_result got mask=%b fidx=%0d exp 1000/3", mask, fidx); else passed++;
  endtask

  task automatic test_reset_mid();
    int de, bc, dc, sb; int seen_done; logic p0; logic [3:0] m0; logic [1:0] f0;
`ifdef TRUTH_TABLE_WALKER_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 2;
`endif
    seen_done = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); if (done) seen_done++; end
    checks++; if (stim !== 2'd1 || busy !== 1'b1) $display("FAIL mid_before_reset got stim=%0d busy=%b exp 1/1", stim, busy); else passed++;
    @(posedge clk); #1 rst_n = 1'b0; #1;
    checks++; if (stim !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || mask !== 4'd0 || fidx !== 2'd0)
      $display("FAIL mid_async_reset got stim=%0d busy=%b done=%b pass=%b mask=%b fidx=%0d exp all 0",
               stim, busy, done, pass, mask, fidx); else passed++;
    repeat (3) begin @(negedge clk); if (done) seen_done++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) seen_done++; end
    checks++; if (seen_done !== 0) $display("FAIL mid_no_done got %0d exp 0", seen_done); else passed++;
    mode = 0;
    run_main(0, 0, 0, de, bc, dc, sb, p0, m0, f0);
    checks++; if (de !== 12 || pass !== 1'b1 || mask !== 4'd0)
      $display("FAIL after_reset_walk got edge=%0d pass=%b mask=%b exp 12/1/0000", de, pass, mask); else passed++;
  endtask

  task automatic test_inverter();
    int e, de, bc, sb;
    de = -1; bc = 0; sb = 0;
    @(negedge clk); start_i = 1'b1;
    @(posedge clk); @(negedge clk); start_i = 1'b0; e = 0;
    while (e < 30 && de < 0) begin
      if (busy_i) bc++;
      if (done_i) de = e;
      else if (e < 6 && stim_i !== 1'(e / 3)) sb++;
      if (de < 0) begin @(posedge clk); @(negedge clk); e++; end
    end
    checks++; if (de !== 6) $display("FAIL inv_done_edge got %0d exp 6", de); else passed++;
    checks++; if (bc !== 6) $display("FAIL inv_busy_cycles got %0d exp 6", bc); else passed++;
    checks++; if (sb !== 0) $display("FAIL inv_stim_sequence got %0d bad cycles exp 0", sb); else passed++;
    checks++; if (pass_i !== 1'b1 || mask_i !== 2'b00 || fidx_i !== 1'b0)
      $display("FAIL inv_result got pass=%b mask=%b fidx=%0d exp 1/00/0", pass_i, mask_i, fidx_i); else passed++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nand();
    test_stuck1();
    test_stuck0();
    test_back_to_back();
    test_reset_mid();
    test_inverter();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
